// File: rtl/cpu_multicycle_if.sv
// Memory bus plus IN/OUT stream handshakes of the multicycle CPU.
// The master side is the CPU; the slave side is memory and the I/O ports.
interface cpu_multicycle_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);
  logic [DATA_WIDTH-1:0] mem;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] in;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out;
  logic                  out_valid;

  modport master (
    input  mem, in, in_valid,
    output we, addr, data, in_ready, out, out_valid
  );

  modport slave (
    output mem, in, in_valid,
    input  we, addr, data, in_ready, out, out_valid
  );
endinterface

// File: rtl/cpu_multicycle.sv
// Multicycle CPU: fetch, decode, operand read, execute, write-back.
// Memory reads take two states: *_A loads the address register, *_R captures mem.
//
// state   | meaning
// IF1     | load address register with pc
// IF2     | capture instruction, pc + 1
// DEC     | decode opcode
// RY_*    | read Y operand (IA/IR only when indirect)
// RZ_*    | read Z operand (IA/IR only when indirect)
// PX_*    | read destination pointer (indirect X only)
// EXE     | ALU result into write data, present write
// WR      | memory write strobe
// IN_WAIT | wait for IN handshake
// RX_*    | read X operand for OUT
// OUTP    | out_valid pulse
// HALT    | stopped until reset
module cpu_multicycle #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int PC_START   = 8,
  parameter int SP_START   = 2**ADDR_WIDTH-1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cpu_multicycle_if.master      bus,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] sp,
  output logic                  halted,
  output logic                  illegal
);
  typedef enum logic [4:0] {
    S_IF1, S_IF2, S_DEC,
    S_RY_A, S_RY_R, S_RY_IA, S_RY_IR,
    S_RZ_A, S_RZ_R, S_RZ_IA, S_RZ_IR,
    S_PX_A, S_PX_R, S_EXE, S_WR, S_IN_WAIT,
    S_RX_A, S_RX_R, S_RX_IA, S_RX_IR, S_OUTP, S_HALT
  } state_t;

  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_DIV  = 4'h4;
  localparam logic [3:0] OP_IN   = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_STOP = 4'hF;

  state_t                state, state_nx, after_y, after_z;
  logic [DATA_WIDTH-1:0] ir, y_val, z_val, alu_res, data_r, out_r;
  logic [ADDR_WIDTH-1:0] pc_r, mar, ptr, ax_ext, ay_ext, az_ext, target;
  logic                  we_r, in_ready_c, out_valid_c;
  logic [3:0]            oc;
  logic                  dx, dy, dz;

  assign oc     = ir[15:12];
  assign dx     = ir[11];
  assign dy     = ir[7];
  assign dz     = ir[3];
  assign ax_ext = ADDR_WIDTH'(ir[10:8]);
  assign ay_ext = ADDR_WIDTH'(ir[6:4]);
  assign az_ext = ADDR_WIDTH'(ir[2:0]);
  assign target = dx ? ptr : ax_ext;

  // MOV skips Z; any instruction with indirect X fetches the pointer first.
  assign after_z = dx ? S_PX_A : S_EXE;
  assign after_y = (oc == OP_MOV) ? after_z : S_RZ_A;

  assign bus.addr      = mar;
  assign bus.data      = data_r;
  assign bus.we        = we_r;
  assign bus.out       = out_r;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign pc            = pc_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IF1;
    else        state <= state_nx;
  end

  // Next-state decode and state-derived handshake outputs.
  always_comb begin
    state_nx    = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      S_IF1:     state_nx = S_IF2;
      S_IF2:     state_nx = S_DEC;
      S_DEC: begin
        case (oc)
          OP_MOV, OP_ADD, OP_SUB, OP_MUL, OP_DIV: state_nx = S_RY_A;
          OP_IN:   state_nx = S_IN_WAIT;
          OP_OUT:  state_nx = S_RX_A;
          default: state_nx = S_HALT;
        endcase
      end
      S_RY_A:    state_nx = S_RY_R;
      S_RY_R:    state_nx = dy ? S_RY_IA : after_y;
      S_RY_IA:   state_nx = S_RY_IR;
      S_RY_IR:   state_nx = after_y;
      S_RZ_A:    state_nx = S_RZ_R;
      S_RZ_R:    state_nx = dz ? S_RZ_IA : after_z;
      S_RZ_IA:   state_nx = S_RZ_IR;
      S_RZ_IR:   state_nx = after_z;
      S_PX_A:    state_nx = S_PX_R;
      S_PX_R:    state_nx = (oc == OP_IN) ? S_WR : S_EXE;
      S_EXE:     state_nx = S_WR;
      S_WR:      state_nx = S_IF1;
      S_IN_WAIT: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nx = dx ? S_PX_A : S_WR;
      end
      S_RX_A:    state_nx = S_RX_R;
      S_RX_R:    state_nx = dx ? S_RX_IA : S_OUTP;
      S_RX_IA:   state_nx = S_RX_IR;
      S_RX_IR:   state_nx = S_OUTP;
      S_OUTP: begin
        out_valid_c = 1'b1;
        state_nx    = S_IF1;
      end
      S_HALT:    state_nx = S_HALT;
      default:   state_nx = S_IF1;
    endcase
  end

  // Unsigned ALU; division by zero saturates to all ones.
  always_comb begin
    alu_res = y_val;
    case (oc)
      OP_ADD:  alu_res = y_val + z_val;
      OP_SUB:  alu_res = y_val - z_val;
      OP_MUL:  alu_res = y_val * z_val;
      OP_DIV:  alu_res = (z_val == '0) ? '1 : y_val / z_val;
      default: alu_res = y_val;
    endcase
  end

  // Datapath registers; write strobe and write data are loaded on entry to WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r    <= ADDR_WIDTH'(PC_START);
      sp      <= ADDR_WIDTH'(SP_START);
      mar     <= '0;
      data_r  <= '0;
      out_r   <= '0;
      we_r    <= 1'b0;
      ir      <= '0;
      y_val   <= '0;
      z_val   <= '0;
      ptr     <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      we_r <= 1'b0;
      case (state)
        S_IF1: mar <= pc_r;
        S_IF2: begin
          ir   <= bus.mem;
          pc_r <= pc_r + ADDR_WIDTH'(1);
        end
        S_DEC: begin
          if (state_nx == S_HALT) begin
            halted  <= 1'b1;
            illegal <= (oc != OP_STOP);
          end
        end
        S_RY_A:           mar   <= ay_ext;
        S_RY_R, S_RY_IR:  y_val <= bus.mem;
        S_RY_IA, S_RX_IA: mar   <= y_val[ADDR_WIDTH-1:0];
        S_RZ_A:           mar   <= az_ext;
        S_RZ_R, S_RZ_IR:  z_val <= bus.mem;
        S_RZ_IA:          mar   <= z_val[ADDR_WIDTH-1:0];
        S_PX_A, S_RX_A:   mar   <= ax_ext;
        S_PX_R: begin
          ptr <= bus.mem[ADDR_WIDTH-1:0];
          if (oc == OP_IN) begin
            mar    <= bus.mem[ADDR_WIDTH-1:0];
            data_r <= y_val;
            we_r   <= 1'b1;
          end
        end
        S_EXE: begin
          mar    <= target;
          data_r <= alu_res;
          we_r   <= 1'b1;
        end
        S_IN_WAIT: begin
          if (bus.in_valid) begin
            y_val <= bus.in;
            if (!dx) begin
              mar    <= ax_ext;
              data_r <= bus.in;
              we_r   <= 1'b1;
            end
          end
        end
        S_RX_R: begin
          y_val <= bus.mem;
          if (!dx) out_r <= bus.mem;
        end
        S_RX_IR: out_r <= bus.mem;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: expected writes and OUT pulses are queued
// when a program is loaded and popped when the CPU produces them.
module tb_cpu_multicycle;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] pc, sp;
  logic halted, illegal;

  cpu_multicycle_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) bus ();

  cpu_multicycle #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .PC_START(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .pc(pc), .sp(sp), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Memory: writes on the rising edge, read data settles in the cycle after addr changes.
  logic [15:0] ram [64];
  always @(posedge clk) if (bus.we) ram[bus.addr] = bus.data;
  always @(negedge clk) bus.mem = ram[bus.addr];

  typedef struct { int kind; int addr; int data; int cycle; } exp_t;
  exp_t sb[$];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in = '0;
    for (int i = 0; i < 64; i++) ram[i] = '0;
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    cyc = 1;
  endtask

  task automatic expect_write(input int a, input int d, input int c);
    exp_t e;
    e.kind = 0; e.addr = a; e.data = d; e.cycle = c;
    sb.push_back(e);
  endtask

  task automatic expect_out(input int d, input int c);
    exp_t e;
    e.kind = 1; e.addr = 0; e.data = d; e.cycle = c;
    sb.push_back(e);
  endtask

  task automatic wait_event(input string tag, input int budget);
    int n;
    bit seen;
    exp_t e;
    n = 0;
    seen = 1'b0;
    while (n < budget && !seen) begin
      tick();
      n++;
      if (bus.we || bus.out_valid) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_we_with_outv"}, 32'(bus.we & bus.out_valid), 32'd0);
      chk({tag, "_sb_pending"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "_kind"}, bus.we ? 32'd0 : 32'd1, 32'(e.kind));
        if (e.kind == 0) chk({tag, "_addr"}, 32'(bus.addr), 32'(e.addr));
        chk({tag, "_data"}, bus.we ? 32'(bus.data) : 32'(bus.out), 32'(e.data));
        chk({tag, "_cycle"}, 32'(cyc), 32'(e.cycle));
      end
    end
  endtask

  task automatic wait_halt(input string tag, input int budget, input int exp_cycle);
    int n;
    n = 0;
    while (n < budget && !halted) begin
      tick();
      n++;
    end
    chk({tag, "_halted"}, 32'(halted), 32'd1);
    chk({tag, "_cycle"}, 32'(cyc), 32'(exp_cycle));
  endtask

  initial begin
    int we_seen;

    // Reset values and MOV direct
    hold_reset();
    chk("rst_pc", 32'(pc), 32'd8);
    chk("rst_sp", 32'(sp), 32'd63);
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_outv", 32'(bus.out_valid), 32'd0);
    chk("rst_inrdy", 32'(bus.in_ready), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    ram[8] = 16'h0120; ram[2] = 16'h1234; ram[9] = 16'hF000;
    expect_write(1, 16'h1234, 7);
    release_reset();
    tick();
    chk("first_addr", 32'(bus.addr), 32'd8);
    wait_event("mov", 20);
    chk("mov_pc", 32'(pc), 32'd9);
    tick();
    tick();
    chk("mov_next_addr", 32'(bus.addr), 32'd9);

    // ADD with indirect Y
    hold_reset();
    ram[8] = 16'h13C5; ram[4] = 16'h0010; ram[16] = 16'd7; ram[5] = 16'd3; ram[9] = 16'hF000;
    expect_write(3, 16'h000A, 11);
    release_reset();
    wait_event("add_iy", 30);

    // SUB wrapping below zero
    hold_reset();
    ram[8] = 16'h2123; ram[2] = 16'd5; ram[3] = 16'd7; ram[9] = 16'hF000;
    expect_write(1, 16'hFFFE, 9);
    release_reset();
    wait_event("sub_wrap", 30);

    // MUL with indirect Z and indirect destination, low bits kept
    hold_reset();
    ram[8] = 16'h392B; ram[1] = 16'h0020; ram[2] = 16'h1234;
    ram[3] = 16'h0021; ram[33] = 16'h0100; ram[9] = 16'hF000;
    expect_write(32, 16'h3400, 13);
    release_reset();
    wait_event("mul_iz_ix", 30);

    // DIV by zero, then a normal DIV
    hold_reset();
    ram[8] = 16'h4123; ram[2] = 16'h1234; ram[3] = 16'h0000;
    ram[9] = 16'h4456; ram[5] = 16'd100; ram[6] = 16'd7; ram[10] = 16'hF000;
    expect_write(1, 16'hFFFF, 9);
    expect_write(4, 16'h000E, 18);
    release_reset();
    wait_event("div_zero", 30);
    wait_event("div_norm", 30);

    // IN handshake with delayed in_valid
    hold_reset();
    ram[8] = 16'h7200; ram[9] = 16'hF000;
    release_reset();
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      chk("in_wait_ready", 32'(bus.in_ready), 32'd1);
      chk("in_wait_we", 32'(bus.we), 32'd0);
      tick();
    end
    bus.in = 16'h00AB;
    bus.in_valid = 1'b1;
    expect_write(2, 16'h00AB, 10);
    wait_event("in", 10);
    chk("in_ready_drop", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;

    // OUT then STOP
    hold_reset();
    ram[8] = 16'h8200; ram[9] = 16'hF000; ram[2] = 16'h0055;
    expect_out(16'h0055, 6);
    release_reset();
    wait_event("out", 20);
    tick();
    chk("out_pulse_len", 32'(bus.out_valid), 32'd0);
    chk("out_held", 32'(bus.out), 32'h55);
    wait_halt("stop", 20, 10);
    chk("stop_illegal", 32'(illegal), 32'd0);
    chk("stop_pc", 32'(pc), 32'd10);
    we_seen = 0;
    repeat (5) begin
      tick();
      if (bus.we) we_seen++;
    end
    chk("halt_no_we", 32'(we_seen), 32'd0);
    chk("halt_pc_frozen", 32'(pc), 32'd10);
    chk("halt_addr_frozen", 32'(bus.addr), 32'd9);

    // OUT with indirect X
    hold_reset();
    ram[8] = 16'h8B00; ram[3] = 16'h0030; ram[48] = 16'hBEEF; ram[9] = 16'hF000;
    expect_out(16'hBEEF, 8);
    release_reset();
    wait_event("out_ind", 20);

    // Illegal opcode
    hold_reset();
    ram[8] = 16'h5000;
    release_reset();
    wait_halt("illegal", 20, 4);
    chk("illegal_flag", 32'(illegal), 32'd1);
    chk("illegal_pc", 32'(pc), 32'd9);

    // Reset asserted during WR
    hold_reset();
    ram[8] = 16'h0120; ram[2] = 16'h1234; ram[9] = 16'hF000;
    expect_write(1, 16'h1234, 7);
    release_reset();
    wait_event("mov_pre_rst", 20);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_we", 32'(bus.we), 32'd0);
    chk("rst_wr_pc", 32'(pc), 32'd8);
    chk("rst_wr_addr", 32'(bus.addr), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
